// File: rtl/newton_raphson_iter.sv
// newton_raphson_iter: multi-cycle Newton-Raphson refinement of a 1/sqrt(x) seed, valid/ready on both sides.
// Optional result/term clamping with sticky sat flag when NR_SAT_EN is defined.
module newton_raphson_iter #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12,
  parameter int ITERS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_half,
  input  logic [WIDTH-1:0] y0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             sat
);
  localparam int L = 2*WIDTH+2;
  localparam logic [L-1:0] ONE5 = L'(3) << (FRAC-1);
  localparam logic [L-1:0] HALF = L'(1) << (FRAC-1);
  localparam logic [1:0]   LAST = 2'(ITERS-1);
  if (ITERS < 1 || ITERS > 4 || FRAC < 1 || FRAC >= WIDTH) begin : g_bad_param
    $error("newton_raphson_iter: illegal WIDTH/FRAC/ITERS");
  end
  typedef enum logic [2:0] {IDLE, M1, M2, M3, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] iter_q, iter_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [L-1:0] t1_q, t1_d, b_q, b_d;
  logic [L-1:0] x_e, y_e, p1, p2, b_raw;
  logic signed [L-1:0] prod, y_nx;
  logic accept;
`ifdef NR_SAT_EN
  localparam logic signed [L-1:0] YMAX = $signed(L'({WIDTH{1'b1}}));
  logic sat_q, sat_d;
  assign sat = sat_q;
`else
  assign sat = 1'b0;
`endif
  assign out_valid = state_q == DONE;
  assign y = y_q;
  always_comb begin
    x_e = L'(x_q);
    y_e = L'(y_q);
    p1 = x_e * y_e;
    p2 = t1_q * y_e;
    b_raw = ONE5 - (p2 >> FRAC);
    prod = $signed(y_e) * $signed(b_q);
    y_nx = (prod + $signed(HALF)) >>> FRAC;
    in_ready = state_q == IDLE || (state_q == DONE && out_ready);
    accept = in_valid && in_ready;
    state_d = state_q;
    iter_d = iter_q;
    x_d = x_q;
    y_d = y_q;
    t1_d = t1_q;
    b_d = b_q;
`ifdef NR_SAT_EN
    sat_d = sat_q;
`endif
    if (accept) begin
      state_d = M1;
      iter_d = 2'd0;
      x_d = x_half;
      y_d = y0;
`ifdef NR_SAT_EN
      sat_d = 1'b0;
`endif
    end else begin
      case (state_q)
        M1: begin
          t1_d = p1 >> FRAC;
          state_d = M2;
        end
        M2: begin
          b_d = b_raw;
`ifdef NR_SAT_EN
          if (b_raw[L-1]) begin
            b_d = '0;
            sat_d = 1'b1;
          end
`endif
          state_d = M3;
        end
        M3: begin
          y_d = WIDTH'(y_nx);
`ifdef NR_SAT_EN
          if (y_nx > YMAX) begin
            y_d = '1;
            sat_d = 1'b1;
          end
`endif
          state_d = iter_q == LAST ? DONE : M1;
          iter_d = iter_q == LAST ? iter_q : iter_q + 2'd1;
        end
        DONE: state_d = out_ready ? IDLE : DONE;
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iter_q <= '0;
      x_q <= '0;
      y_q <= '0;
      t1_q <= '0;
      b_q <= '0;
`ifdef NR_SAT_EN
      sat_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      iter_q <= iter_d;
      x_q <= x_d;
      y_q <= y_d;
      t1_q <= t1_d;
      b_q <= b_d;
`ifdef NR_SAT_EN
      sat_q <= sat_d;
`endif
    end
  end
endmodule

// File: tb/tb_newton_raphson_iter.sv
// tb_newton_raphson_iter: directed and randomized checks of newton_raphson_iter (ITERS=1 and ITERS=2 instances).
module tb_newton_raphson_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] in_valid, in_ready, out_valid, out_ready, sat;
  logic [1:0][15:0] x_half, y0, y;
  int checks = 0;
  int errors = 0;
  int lat;
  bit seen;
  logic s_exp;
  logic [15:0] y_exp;
  always #5 clk = ~clk;

  newton_raphson_iter #(.WIDTH(16), .FRAC(12), .ITERS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .x_half(x_half[0]), .y0(y0[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .y(y[0]), .sat(sat[0]));
  newton_raphson_iter #(.WIDTH(16), .FRAC(12), .ITERS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .x_half(x_half[1]), .y0(y0[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .y(y[1]), .sat(sat[1]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Sign-extend a 34-bit (2*WIDTH+2) quantity held in a longint.
  function automatic longint sx(input longint v);
    return (v <<< 30) >>> 30;
  endfunction

  function automatic logic [15:0] ref_nr(input longint xh, input longint ys, input int iters, output logic s);
    longint m = (64'sd1 <<< 34) - 1;
    longint yv = ys;
    longint t1, p2, b, yn;
    s = 1'b0;
    for (int i = 0; i < iters; i++) begin
      t1 = ((xh * yv) & m) >> 12;
      p2 = ((t1 * yv) & m) >> 12;
      b = sx(6144 - p2);
`ifdef NR_SAT_EN
      if (b < 0) begin
        b = 0;
        s = 1'b1;
      end
`endif
      yn = sx(sx(yv * b) + 2048) >>> 12;
`ifdef NR_SAT_EN
      if (yn > 65535) begin
        yn = 65535;
        s = 1'b1;
      end
`endif
      yv = yn & 64'hFFFF;
    end
    return yv[15:0];
  endfunction

  // Offer one operand at a negedge, wait for acceptance, then count cycles until out_valid.
  task automatic op(input int k, input logic [15:0] xh, input logic [15:0] ys, output int l);
    int g = 0;
    in_valid[k] = 1'b1;
    x_half[k] = xh;
    y0[k] = ys;
    #1;
    while (!in_ready[k] && g < 20) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("accept", in_ready[k], 1);
    @(negedge clk);
    in_valid[k] = 1'b0;
    l = 0;
    while (!out_valid[k] && l < 50) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic random_run(input int k, input int n);
    logic [16:0] q[$];
    logic [16:0] front;
    logic s;
    logic [15:0] e;
    int sent = 0, got = 0, cyc = 0;
    bit acc = 0;
    in_valid[k] = 1'b0;
    while (got < n && cyc < 40 * n) begin
      @(negedge clk);
      cyc++;
      if (acc) in_valid[k] = 1'b0;
      acc = 0;
      if (!in_valid[k] && sent < n && $urandom_range(3) != 0) begin
        in_valid[k] = 1'b1;
        x_half[k] = 16'($urandom);
        y0[k] = $urandom_range(1) != 0 ? 16'($urandom) : 16'($urandom_range(16'h2000));
      end
      out_ready[k] = $urandom_range(3) != 0;
      #1;
      if (out_valid[k] && out_ready[k]) begin
        check("rnd_expected_pending", q.size() != 0, 1);
        if (q.size() != 0) begin
          front = q.pop_front();
          check("rnd_y", y[k], front[15:0]);
          check("rnd_sat", sat[k], front[16]);
        end
        got++;
      end
      if (in_valid[k] && in_ready[k]) begin
        e = ref_nr(x_half[k], y0[k], k + 1, s);
        q.push_back({s, e});
        sent++;
        acc = 1;
      end
    end
    @(negedge clk);
    in_valid[k] = 1'b0;
    check("rnd_count", got, n);
  endtask

  initial begin
    in_valid = '0;
    out_ready = '0;
    x_half = '0;
    y0 = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_out_valid", out_valid[k], 0);
      check("rst_y", y[k], 0);
      check("rst_sat", sat[k], 0);
      check("rst_in_ready", in_ready[k], 1);
    end
    rst_n = 1'b1;
    @(negedge clk);

    op(0, 16'h1000, 16'h0B33, lat);
    check("i1_latency", lat, 3);
    check("i1_y", y[0], 16'h0B50);
    check("i1_sat", sat[0], 0);
    y_exp = ref_nr(16'h1000, 16'h0B33, 1, s_exp);
    check("i1_model", y[0], y_exp);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid[0], 1);
      check("bp_y", y[0], 16'h0B50);
      check("bp_sat", sat[0], 0);
      check("bp_in_ready", in_ready[0], 0);
    end

    out_ready[0] = 1'b1;
    op(0, 16'h1000, 16'h3000, lat);
    check("handoff_latency", lat, 3);
`ifdef NR_SAT_EN
    check("big_y", y[0], 16'h0000);
    check("big_sat", sat[0], 1);
`else
    check("big_y", y[0], 16'h9800);
    check("big_sat", sat[0], 0);
`endif
    y_exp = ref_nr(16'h1000, 16'h3000, 1, s_exp);
    check("big_model", {sat[0], y[0]}, {s_exp, y_exp});
    @(negedge clk);
    check("drain_valid", out_valid[0], 0);
    check("drain_in_ready", in_ready[0], 1);

    out_ready[1] = 1'b1;
    op(1, 16'h1000, 16'h0B33, lat);
    check("i2_latency", lat, 6);
    check("i2_y", y[1], 16'h0B51);
    check("i2_sat", sat[1], 0);

    op(0, 16'h0000, 16'h0800, lat);
    check("xzero_y", y[0], 16'h0C00);
    op(0, 16'h1234, 16'h0000, lat);
    check("yzero_y", y[0], 16'h0000);
    @(negedge clk);

    in_valid[0] = 1'b1;
    x_half[0] = 16'h1000;
    y0[0] = 16'h0B33;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", out_valid[0], 0);
    check("midrst_y", y[0], 0);
    check("midrst_in_ready", in_ready[0], 1);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1;
    end
    check("midrst_no_stale", seen, 0);

    random_run(0, 1500);
    random_run(1, 1500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
